decode_8b10b: RTL and testbench



---
 rtl/decode_8b10b_pkg.sv | 122 ++++++++++++
 rtl/decode_6b4b_lut.sv | 82 ++++++++
 rtl/decode_8b10b.sv | 83 ++++++++
 tb/tb_decode_8b10b.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/decode_8b10b_pkg.sv
// Shared 8b/10b constants and lookup helpers, used by the decoder.
// The 8b/10b encoder also imports this package, so the code tables live in one place.
package decode_8b10b_pkg;

   // Control byte values
   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K23_7 = 8'hF7;
   localparam logic [7:0] K27_7 = 8'hFB;
   localparam logic [7:0] K29_7 = 8'hFD;
   localparam logic [7:0] K30_7 = 8'hFE;
   localparam logic [4:0] K28_5B = 5'd28;

   // K28 6b sub-blocks (RD- form, RD+ form)
   localparam logic [5:0] K28_6B_RDN = 6'b001111;
   localparam logic [5:0] K28_6B_RDP = 6'b110000;

   // Alternate / primary y=7 4b sub-blocks
   localparam logic [3:0] A7_RDN_4B = 4'b0111;
   localparam logic [3:0] A7_RDP_4B = 4'b1000;
   localparam logic [3:0] P7_RDN_4B = 4'b1110;
   localparam logic [3:0] P7_RDP_4B = 4'b0001;

   // 5b values that take A7 at RD- and at RD+ respectively
   localparam logic [4:0] A7N_0 = 5'd17;
   localparam logic [4:0] A7N_1 = 5'd18;
   localparam logic [4:0] A7N_2 = 5'd20;
   localparam logic [4:0] A7P_0 = 5'd11;
   localparam logic [4:0] A7P_1 = 5'd13;
   localparam logic [4:0] A7P_2 = 5'd14;

   function automatic logic is_a7_rdn(input logic [4:0] x);
      return (x == A7N_0) || (x == A7N_1) || (x == A7N_2);
   endfunction

   function automatic logic is_a7_rdp(input logic [4:0] x);
      return (x == A7P_0) || (x == A7P_1) || (x == A7P_2);
   endfunction

   // 5b values that form K.x.7 with an A7-shaped 4b
   function automatic logic is_k7_5b(input logic [4:0] x);
      return (x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30);
   endfunction

   function automatic logic [2:0] ones6(input logic [5:0] v);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 6; i++) n = n + {2'b00, v[i]};
      return n;
   endfunction

   // 6b -> {legal, 5b EDCBA}; both RD forms map to the same value
   function automatic logic [5:0] dec6(input logic [5:0] s);
      case (s)
         6'b100111, 6'b011000: return {1'b1, 5'd0};
         6'b011101, 6'b100010: return {1'b1, 5'd1};
         6'b101101, 6'b010010: return {1'b1, 5'd2};
         6'b110001:            return {1'b1, 5'd3};
         6'b110101, 6'b001010: return {1'b1, 5'd4};
         6'b101001:            return {1'b1, 5'd5};
         6'b011001:            return {1'b1, 5'd6};
         6'b111000, 6'b000111: return {1'b1, 5'd7};
         6'b111001, 6'b000110: return {1'b1, 5'd8};
         6'b100101:            return {1'b1, 5'd9};
         6'b010101:            return {1'b1, 5'd10};
         6'b110100:            return {1'b1, 5'd11};
         6'b001101:            return {1'b1, 5'd12};
         6'b101100:            return {1'b1, 5'd13};
         6'b011100:            return {1'b1, 5'd14};
         6'b010111, 6'b101000: return {1'b1, 5'd15};
         6'b011011, 6'b100100: return {1'b1, 5'd16};
         6'b100011:            return {1'b1, 5'd17};
         6'b010011:            return {1'b1, 5'd18};
         6'b110010:            return {1'b1, 5'd19};
         6'b001011:            return {1'b1, 5'd20};
         6'b101010:            return {1'b1, 5'd21};
         6'b011010:            return {1'b1, 5'd22};
         6'b111010, 6'b000101: return {1'b1, 5'd23};
         6'b110011, 6'b001100: return {1'b1, 5'd24};
         6'b100110:            return {1'b1, 5'd25};
         6'b010110:            return {1'b1, 5'd26};
         6'b110110, 6'b001001: return {1'b1, 5'd27};
         6'b001110:            return {1'b1, 5'd28};
         6'b001111, 6'b110000: return {1'b1, 5'd28};
         6'b101110, 6'b010001: return {1'b1, 5'd29};
         6'b011110, 6'b100001: return {1'b1, 5'd30};
         6'b101011, 6'b010100: return {1'b1, 5'd31};
         default:              return 6'b000000;
      endcase
   endfunction

   // Data 4b -> {legal, 3b HGF}; P7 and A7 both give 7
   function automatic logic [3:0] dec4(input logic [3:0] s);
      case (s)
         4'b1011, 4'b0100: return {1'b1, 3'd0};
         4'b1001:          return {1'b1, 3'd1};
         4'b0101:          return {1'b1, 3'd2};
         4'b1100, 4'b0011: return {1'b1, 3'd3};
         4'b1101, 4'b0010: return {1'b1, 3'd4};
         4'b1010:          return {1'b1, 3'd5};
         4'b0110:          return {1'b1, 3'd6};
         4'b1110, 4'b0001,
         4'b0111, 4'b1000: return {1'b1, 3'd7};
         default:          return 4'b0000;
      endcase
   endfunction

   // K28 4b as it follows 001111; after 110000 the caller inverts first
   function automatic logic [3:0] dec4_k28(input logic [3:0] s);
      case (s)
         4'b0100: return {1'b1, 3'd0};
         4'b1001: return {1'b1, 3'd1};
         4'b0101: return {1'b1, 3'd2};
         4'b0011: return {1'b1, 3'd3};
         4'b0010: return {1'b1, 3'd4};
         4'b1010: return {1'b1, 3'd5};
         4'b0110: return {1'b1, 3'd6};
         4'b1000: return {1'b1, 3'd7};
         default: return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/decode_6b4b_lut.sv
// Combinational 10b -> 8b decode with code and running-disparity checks.
module decode_6b4b_lut
   import decode_8b10b_pkg::*;
(
   input  logic [9:0] sym,
   input  logic       rd,
   output logic [7:0] data_dec,
   output logic       k_dec,
   output logic       code_err,
   output logic       disp_err,
   output logic       rd_next
);

   logic [5:0] sub6;
   logic [3:0] sub4;
   logic [2:0] n6;
   logic [2:0] n4;
   logic [5:0] e6;
   logic [3:0] e4;
   logic [3:0] ek;
   logic [3:0] k28_4b;
   logic [4:0] x5;
   logic [2:0] y3;
   logic       is_k28;
   logic       bad;
   logic       kflag;
   logic       rd_mid;
   logic       d6_err;
   logic       d4_err;
   logic       rd_calc;

   assign sub6 = sym[9:4];
   assign sub4 = sym[3:0];

   // Table lookup, y=7 / K-code legality, then disparity tracking
   always_comb begin
      n6      = ones6(sub6);
      n4      = ones6({2'b00, sub4});
      e6      = dec6(sub6);
      e4      = dec4(sub4);
      is_k28  = (sub6 == K28_6B_RDN) || (sub6 == K28_6B_RDP);
      k28_4b  = (sub6 == K28_6B_RDP) ? ~sub4 : sub4;
      ek      = dec4_k28(k28_4b);
      x5      = e6[4:0];
      y3      = e4[2:0];
      bad     = 1'b0;
      kflag   = 1'b0;

      if (!e6[5] || !e4[3]) begin
         bad = 1'b1;
      end else if (is_k28) begin
         kflag = 1'b1;
         y3    = ek[2:0];
         bad   = !ek[3];
      end else if (sub4 == A7_RDN_4B) begin
         if (is_k7_5b(x5))        kflag = 1'b1;
         else if (!is_a7_rdn(x5)) bad   = 1'b1;
      end else if (sub4 == A7_RDP_4B) begin
         if (is_k7_5b(x5))        kflag = 1'b1;
         else if (!is_a7_rdp(x5)) bad   = 1'b1;
      end else if ((sub4 == P7_RDN_4B) && is_a7_rdn(x5)) begin
         bad = 1'b1;
      end else if ((sub4 == P7_RDP_4B) && is_a7_rdp(x5)) begin
         bad = 1'b1;
      end

      // 111000 / 000111 and 1100 / 0011 are neutral but RD-specific
      d6_err = ((n6 == 3'd4) && rd) || ((n6 == 3'd2) && !rd) ||
               ((sub6 == 6'b111000) && rd) || ((sub6 == 6'b000111) && !rd);
      rd_mid = (n6 == 3'd3) ? rd : (n6 == 3'd4);
      d4_err = ((n4 == 3'd3) && rd_mid) || ((n4 == 3'd1) && !rd_mid) ||
               ((sub4 == 4'b1100) && rd_mid) || ((sub4 == 4'b0011) && !rd_mid);
      rd_calc = (n4 == 3'd2) ? rd_mid : (n4 == 3'd3);

      code_err = bad;
      disp_err = !bad && (d6_err || d4_err);
      k_dec    = !bad && kflag;
      data_dec = bad ? 8'h00 : {y3, x5};
      rd_next  = bad ? rd : rd_calc;
   end

endmodule

// File: rtl/decode_8b10b.sv
// 8b/10b receive decoder: one-cycle registered decode with RD tracking.
// Optional error counters are enabled by defining DECODE_8B10B_STATS_EN.
module decode_8b10b
   import decode_8b10b_pkg::*;
`ifdef DECODE_8B10B_STATS_EN
#(
   parameter int CNT_W = 16
)
`endif
(
   input  logic       clk,
   input  logic       rst,
   input  logic       valid_in,
   input  logic [9:0] data_in,
   output logic [7:0] data_out,
   output logic       k_out,
   output logic       valid,
   output logic       code_err,
   output logic       disp_err,
   output logic       rd
`ifdef DECODE_8B10B_STATS_EN
   ,
   output logic [CNT_W-1:0] err_cnt_code,
   output logic [CNT_W-1:0] err_cnt_disp
`endif
);

   logic [7:0] dec_data;
   logic       dec_k;
   logic       dec_code_err;
   logic       dec_disp_err;
   logic       dec_rd_next;

   decode_6b4b_lut u_lut (
      .sym      (data_in),
      .rd       (rd),
      .data_dec (dec_data),
      .k_dec    (dec_k),
      .code_err (dec_code_err),
      .disp_err (dec_disp_err),
      .rd_next  (dec_rd_next)
   );

   // Output register; idle cycles hold data/k/rd and drop the error pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out <= 8'h00;
         k_out    <= 1'b0;
         valid    <= 1'b0;
         code_err <= 1'b0;
         disp_err <= 1'b0;
         rd       <= 1'b0;
      end else begin
         valid <= valid_in;
         if (valid_in) begin
            data_out <= dec_data;
            k_out    <= dec_k;
            code_err <= dec_code_err;
            disp_err <= dec_disp_err;
            rd       <= dec_rd_next;
         end else begin
            code_err <= 1'b0;
            disp_err <= 1'b0;
         end
      end
   end

`ifdef DECODE_8B10B_STATS_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Saturating error counters
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_code <= '0;
         err_cnt_disp <= '0;
      end else if (valid_in) begin
         if (dec_code_err && (err_cnt_code != '1)) err_cnt_code <= err_cnt_code + CNT_ONE;
         if (dec_disp_err && (err_cnt_disp != '1)) err_cnt_disp <= err_cnt_disp + CNT_ONE;
      end
   end
`endif

endmodule

// File: tb/tb_decode_8b10b.sv
// Directed bench for decode_8b10b with hand-computed expectations.
module tb_decode_8b10b;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid_in;
   logic [9:0] data_in;
   logic [7:0] data_out;
   logic       k_out;
   logic       valid;
   logic       code_err;
   logic       disp_err;
   logic       rd;
`ifdef DECODE_8B10B_STATS_EN
   logic [15:0] err_cnt_code;
   logic [15:0] err_cnt_disp;
`endif

   int tests = 0;
   int fails = 0;

   decode_8b10b dut (
      .clk          (clk),
      .rst          (rst),
      .valid_in     (valid_in),
      .data_in      (data_in),
      .data_out     (data_out),
      .k_out        (k_out),
      .valid        (valid),
      .code_err     (code_err),
      .disp_err     (disp_err),
      .rd           (rd)
`ifdef DECODE_8B10B_STATS_EN
      ,
      .err_cnt_code (err_cnt_code),
      .err_cnt_disp (err_cnt_disp)
`endif
   );

   always #5 clk = ~clk;

   task automatic step(input logic r, input logic v, input logic [9:0] s);
      @(negedge clk);
      rst      = r;
      valid_in = v;
      data_in  = s;
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [7:0] e_data, input logic e_k,
                            input logic e_code, input logic e_disp, input logic e_rd,
                            input logic e_valid);
      tests++;
      assert (data_out === e_data) else begin
         fails++; $error("FAIL %s data_out observed=%h expected=%h", tag, data_out, e_data);
      end
      tests++;
      assert (k_out === e_k) else begin
         fails++; $error("FAIL %s k_out observed=%b expected=%b", tag, k_out, e_k);
      end
      tests++;
      assert (code_err === e_code) else begin
         fails++; $error("FAIL %s code_err observed=%b expected=%b", tag, code_err, e_code);
      end
      tests++;
      assert (disp_err === e_disp) else begin
         fails++; $error("FAIL %s disp_err observed=%b expected=%b", tag, disp_err, e_disp);
      end
      tests++;
      assert (rd === e_rd) else begin
         fails++; $error("FAIL %s rd observed=%b expected=%b", tag, rd, e_rd);
      end
      tests++;
      assert (valid === e_valid) else begin
         fails++; $error("FAIL %s valid observed=%b expected=%b", tag, valid, e_valid);
      end
   endtask

`ifdef DECODE_8B10B_STATS_EN
   task automatic check_cnt(input string tag, input logic [15:0] e_code, input logic [15:0] e_disp);
      tests++;
      assert (err_cnt_code === e_code) else begin
         fails++; $error("FAIL %s err_cnt_code observed=%0d expected=%0d", tag, err_cnt_code, e_code);
      end
      tests++;
      assert (err_cnt_disp === e_disp) else begin
         fails++; $error("FAIL %s err_cnt_disp observed=%0d expected=%0d", tag, err_cnt_disp, e_disp);
      end
   endtask
`endif

   initial begin
      rst      = 1'b1;
      valid_in = 1'b0;
      data_in  = 10'b0;

      // Reset with a symbol presented: it must be discarded
      step(1'b1, 1'b1, 10'b0011111010);
      step(1'b1, 1'b1, 10'b0011111010);
      check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef DECODE_8B10B_STATS_EN
      check_cnt("reset_cnt", 16'd0, 16'd0);
`endif

      // D.00 at RD-
      step(1'b0, 1'b1, 10'b1001110100);
      check_out("d00_rdn", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // K28.5 at RD-, idle hold, then K28.5 at RD+
      step(1'b0, 1'b1, 10'b0011111010);
      check_out("k285_rdn", 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 10'b0000000000);
      check_out("idle_hold", 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 10'b1100000101);
      check_out("k285_rdp", 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

      // RD+ K28.5 while rd=0: disparity error, rd stays 0
      step(1'b0, 1'b1, 10'b1100000101);
      check_out("k285_wrong_rd", 8'hBC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

      // All-zero and all-one symbols are not in the code
      step(1'b0, 1'b1, 10'b0000000000);
      check_out("all_zero", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 10'b1111111111);
      check_out("all_one", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef DECODE_8B10B_STATS_EN
      check_cnt("cnt_after_codes", 16'd2, 16'd1);
`endif

      // D.07.0 sequence
      step(1'b0, 1'b1, 10'b1110001011);
      check_out("d070_rdn", 8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 10'b0001110100);
      check_out("d070_rdp", 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 10'b0001110100);
      check_out("d070_wrong_rd", 8'h07, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

      // D.17.7 uses A7 at RD-, then P7 misuse with 5b=17
      step(1'b0, 1'b1, 10'b1000110111);
      check_out("d177_a7", 8'hF1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 10'b1000111110);
      check_out("p7_misuse", 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

      // K28.3 RD+ form at rd=1 -> 8'h7C
      step(1'b0, 1'b1, 10'b1100001100);
      check_out("k283_rdp", 8'h7C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

      // K.23.7 RD- form at rd=0 -> 8'hF7
      step(1'b0, 1'b1, 10'b1110101000);
      check_out("k237_rdn", 8'hF7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

      // K28 6b with a 4b outside the K28 table
      step(1'b0, 1'b1, 10'b0011110111);
      check_out("k28_bad_4b", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

      // Unused 6b pattern 111100 (n6=4 but not in the table)
      step(1'b0, 1'b1, 10'b1111000101);
      check_out("bad_6b", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef DECODE_8B10B_STATS_EN
      check_cnt("cnt_before_rst", 16'd5, 16'd2);
`endif

      // Drive rd to 1, then reset mid-stream with a symbol presented
      step(1'b0, 1'b1, 10'b1110001011);
      check_out("pre_rst", 8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 10'b1000110111);
      check_out("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef DECODE_8B10B_STATS_EN
      check_cnt("cnt_mid_rst", 16'd0, 16'd0);
`endif
      step(1'b0, 1'b0, 10'b0000000000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout tests=%0d", tests);
      $fatal(1, "timeout");
   end

endmodule
